// File: rtl/sonic_vc_pkt_adapter_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module     : sonic_vc_pkt_adapter_fifo_if
//  Description: Valid/ready bus between the VC TX packet source, the adapter
//               FIFO and the PCS-side sink.
//               in_*  : write side (source -> FIFO)
//               out_* : read side  (FIFO -> sink)
//               slave modport  = FIFO view, master modport = source/sink view
//  Revision   : 1.0  initial release
// ============================================================================
interface sonic_vc_pkt_adapter_fifo_if #(
    parameter int DATA_WIDTH = 133
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_eop;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_eop;

    modport slave (
        input  in_valid, in_data, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_eop
    );

    modport master (
        output in_valid, in_data, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_eop
    );
endinterface
`default_nettype wire

// File: rtl/sonic_vc_pkt_adapter_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : sonic_vc_pkt_adapter_fifo
//  Description: Per-virtual-channel adapter FIFO with registered output,
//               almost-full/almost-empty flags, synchronous flush and an
//               optional store-and-forward packet mode that falls back to
//               cut-through when a packet does not fit.
//  Ports      : clk          - rising-edge clock
//               reset_n      - asynchronous active-low reset
//               flush        - synchronous clear of pointers/counters
//               bus          - valid/ready data bus (slave modport)
//               fill_level   - words held, 0..DEPTH (incl. word on output)
//               almost_full  - fill_level >= AF_THRESH
//               almost_empty - fill_level <= AE_THRESH
//  Revision   : 1.0  initial release
// ============================================================================
module sonic_vc_pkt_adapter_fifo #(
    parameter int DATA_WIDTH = 133,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8,    // must equal 2**ADDR_WIDTH
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1,
    parameter int PKT_MODE   = 0
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    input  wire logic                    flush,
    sonic_vc_pkt_adapter_fifo_if.slave   bus,
    output logic [ADDR_WIDTH:0]          fill_level,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] c_AE    = (ADDR_WIDTH+1)'(AE_THRESH);

    typedef enum logic [0:0] {
        S_HOLD = 1'b0,
        S_CUT  = 1'b1
    } state_t;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_full;
    logic                  r_empty;
    logic [ADDR_WIDTH:0]   r_pkt_count;
    state_t                r_state;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_eop;

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_wr_next;
    logic [ADDR_WIDTH-1:0] w_rd_next;
    logic [ADDR_WIDTH:0]   w_stored_after;
    logic [ADDR_WIDTH:0]   w_pkt_after;
    logic                  w_pkt_inc;
    logic                  w_pkt_dec;
    state_t                w_state_next;
    logic                  w_gate;
    logic                  w_ov_next;
    logic [DATA_WIDTH-1:0] w_od_next;
    logic                  w_oe_next;
    logic [DATA_WIDTH:0]   w_head;

    assign w_in_ready = !r_full && !flush;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = r_out_valid && bus.out_ready;
    assign w_wr_next  = r_wr_addr + ADDR_WIDTH'(1);
    assign w_rd_next  = r_rd_addr + ADDR_WIDTH'(1);

    assign fill_level   = r_full ? c_DEPTH : {1'b0, r_wr_addr - r_rd_addr};
    assign almost_full  = (fill_level >= c_AF);
    assign almost_empty = (fill_level <= c_AE);

    // Words already in the array that can feed the output register after this
    // edge; a word being written at this same edge is not yet readable.
    assign w_stored_after = fill_level - {ADDR_WIDTH'(0), w_pop};

    assign w_pkt_inc   = (PKT_MODE != 0) && w_push && bus.in_eop;
    assign w_pkt_dec   = (PKT_MODE != 0) && w_pop && r_out_eop;
    assign w_pkt_after = r_pkt_count - {ADDR_WIDTH'(0), w_pkt_dec};

    assign w_head = r_mem[w_pop ? w_rd_next : r_rd_addr];

    // Packet-mode FSM next state and output-register next values
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_HOLD) begin
            // A full FIFO with no complete packet can only drain by cutting
            // through; otherwise source and sink would deadlock.
            if ((PKT_MODE != 0) && r_full && (r_pkt_count == '0))
                w_state_next = S_CUT;
        end else begin
            if (w_pop && r_out_eop)
                w_state_next = S_HOLD;
        end

        // Head word may be presented once its packet's EOP is stored.
        w_gate = (PKT_MODE == 0) || (w_state_next == S_CUT) || (w_pkt_after != '0);

        w_ov_next = r_out_valid;
        w_od_next = r_out_data;
        w_oe_next = r_out_eop;
        if (!r_out_valid || w_pop) begin
            if (w_stored_after != '0) begin
                w_ov_next = w_gate;
                w_od_next = w_head[DATA_WIDTH-1:0];
                w_oe_next = w_head[DATA_WIDTH];
            end else if (w_pop && w_push) begin
                // Single-word occupancy with push+pop: forward the incoming
                // word so continuous streaming has no bubble.
                w_ov_next = w_gate;
                w_od_next = bus.in_data;
                w_oe_next = bus.in_eop;
            end else begin
                w_ov_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_addr] <= {bus.in_eop, bus.in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_pkt_count <= '0;
            r_state     <= S_HOLD;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eop   <= 1'b0;
        end else if (flush) begin
            // Array contents and the output data register are left as-is.
            r_wr_addr   <= '0;
            r_rd_addr   <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_pkt_count <= '0;
            r_state     <= S_HOLD;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push)
                r_wr_addr <= w_wr_next;
            if (w_pop)
                r_rd_addr <= w_rd_next;

            if (w_push && !w_pop) begin
                r_empty <= 1'b0;
                r_full  <= (w_wr_next == r_rd_addr);
            end else if (w_pop && !w_push) begin
                r_full  <= 1'b0;
                r_empty <= (w_rd_next == r_wr_addr);
            end

            if (w_pkt_inc && !w_pkt_dec)
                r_pkt_count <= r_pkt_count + (ADDR_WIDTH+1)'(1);
            else if (w_pkt_dec && !w_pkt_inc)
                r_pkt_count <= r_pkt_count - (ADDR_WIDTH+1)'(1);

            r_state     <= w_state_next;
            r_out_valid <= w_ov_next;
            r_out_data  <= w_od_next;
            r_out_eop   <= w_oe_next;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_eop   = r_out_eop;

endmodule
`default_nettype wire

// File: tb/tb_sonic_vc_pkt_adapter_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : tb_sonic_vc_pkt_adapter_fifo
//  Description: Self-checking bench. One word-mode instance (dut_w) and one
//               packet-mode instance (dut_p) share clock, reset and flush.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_sonic_vc_pkt_adapter_fifo;

    localparam int DW = 133;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    sonic_vc_pkt_adapter_fifo_if #(.DATA_WIDTH(DW)) bus_w ();
    sonic_vc_pkt_adapter_fifo_if #(.DATA_WIDTH(DW)) bus_p ();

    logic [3:0] fill_w, fill_p;
    logic       af_w, ae_w, af_p, ae_p;

    sonic_vc_pkt_adapter_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .DEPTH(8),
        .AF_THRESH(6), .AE_THRESH(1), .PKT_MODE(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus_w.slave),
        .fill_level(fill_w), .almost_full(af_w), .almost_empty(ae_w));

    sonic_vc_pkt_adapter_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(3), .DEPTH(8),
        .AF_THRESH(6), .AE_THRESH(1), .PKT_MODE(1)) dut_p (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus_p.slave),
        .fill_level(fill_p), .almost_full(af_p), .almost_empty(ae_p));

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       eop;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic [7:0] od;
        logic [3:0] fill;
        logic       af;
        logic       ae;
        logic       ir;
    } vec_t;

    vec_t tbl [25];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int pre);
        int base;
        base = pre * 256;
        bus_w.out_ready = L;
        for (int k = 0; k < pre; k++) begin
            bus_w.in_valid = H;
            bus_w.in_data  = DW'(base + k);
            bus_w.in_eop   = L;
            step();
        end
        bus_w.in_valid = L;
        step();
        chk("stream_prefill_valid", 136'(bus_w.out_valid), 136'(1));
        chk("stream_prefill_data", 136'(bus_w.out_data), 136'(base));
        for (int c = 0; c < 40; c++) begin
            bus_w.in_valid  = H;
            bus_w.in_data   = DW'(base + pre + c);
            bus_w.out_ready = H;
            step();
            chk("stream_valid", 136'(bus_w.out_valid), 136'(1));
            chk("stream_data", 136'(bus_w.out_data), 136'(base + c + 1));
            chk("stream_fill", 136'(fill_w), 136'(pre));
        end
        bus_w.in_valid = L;
        for (int k = 0; k < pre; k++)
            step();
        chk("stream_drain_valid", 136'(bus_w.out_valid), 136'(0));
        chk("stream_drain_fill", 136'(fill_w), 136'(0));
        bus_w.out_ready = L;
    endtask

    task automatic push_p(input logic [7:0] d, input logic eop);
        bus_p.in_valid = H;
        bus_p.in_data  = DW'(d);
        bus_p.in_eop   = eop;
        step();
        bus_p.in_valid = L;
        bus_p.in_eop   = L;
    endtask

    task automatic chk_p(input string name, input logic ov, input logic [7:0] d, input logic eop);
        chk({name, "_valid"}, 136'(bus_p.out_valid), 136'(ov));
        if (ov) begin
            chk({name, "_data"}, 136'(bus_p.out_data), 136'(d));
            chk({name, "_eop"}, 136'(bus_p.out_eop), 136'(eop));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, rcv, maxfill;
        logic pushed, popped, pe;
        logic [DW-1:0] pd;

        //            iv d      eop ordy fl  ov od     fill af ae ir
        tbl[0]  = '{H, 8'h00, L, L, L, L, 8'h00, 4'd1, L, H, H};
        tbl[1]  = '{H, 8'h01, L, L, L, H, 8'h00, 4'd2, L, L, H};
        tbl[2]  = '{H, 8'h02, L, L, L, H, 8'h00, 4'd3, L, L, H};
        tbl[3]  = '{H, 8'h03, L, L, L, H, 8'h00, 4'd4, L, L, H};
        tbl[4]  = '{H, 8'h04, L, L, L, H, 8'h00, 4'd5, L, L, H};
        tbl[5]  = '{H, 8'h05, L, L, L, H, 8'h00, 4'd6, H, L, H};
        tbl[6]  = '{H, 8'h06, L, L, L, H, 8'h00, 4'd7, H, L, H};
        tbl[7]  = '{H, 8'h07, L, L, L, H, 8'h00, 4'd8, H, L, L};
        tbl[8]  = '{L, 8'h00, L, H, L, H, 8'h01, 4'd7, H, L, H};
        tbl[9]  = '{L, 8'h00, L, H, L, H, 8'h02, 4'd6, H, L, H};
        tbl[10] = '{L, 8'h00, L, H, L, H, 8'h03, 4'd5, L, L, H};
        tbl[11] = '{L, 8'h00, L, H, L, H, 8'h04, 4'd4, L, L, H};
        tbl[12] = '{L, 8'h00, L, H, L, H, 8'h05, 4'd3, L, L, H};
        tbl[13] = '{L, 8'h00, L, H, L, H, 8'h06, 4'd2, L, L, H};
        tbl[14] = '{L, 8'h00, L, H, L, H, 8'h07, 4'd1, L, H, H};
        tbl[15] = '{L, 8'h00, L, H, L, L, 8'h00, 4'd0, L, H, H};
        tbl[16] = '{H, 8'h10, L, L, L, L, 8'h00, 4'd1, L, H, H};
        tbl[17] = '{H, 8'h11, L, L, L, H, 8'h10, 4'd2, L, L, H};
        tbl[18] = '{H, 8'h12, L, L, L, H, 8'h10, 4'd3, L, L, H};
        tbl[19] = '{H, 8'h13, L, L, L, H, 8'h10, 4'd4, L, L, H};
        tbl[20] = '{H, 8'h14, L, L, L, H, 8'h10, 4'd5, L, L, H};
        tbl[21] = '{H, 8'h99, L, H, H, L, 8'h00, 4'd0, L, H, L};
        tbl[22] = '{H, 8'hA5, L, H, L, L, 8'h00, 4'd1, L, H, H};
        tbl[23] = '{L, 8'h00, L, H, L, H, 8'hA5, 4'd1, L, H, H};
        tbl[24] = '{L, 8'h00, L, H, L, L, 8'h00, 4'd0, L, H, H};

        bus_w.in_valid = L; bus_w.in_data = '0; bus_w.in_eop = L; bus_w.out_ready = L;
        bus_p.in_valid = L; bus_p.in_data = '0; bus_p.in_eop = L; bus_p.out_ready = L;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = H;

        // Reset state
        chk("rst_w_valid", 136'(bus_w.out_valid), 136'(0));
        chk("rst_w_data", 136'(bus_w.out_data), 136'(0));
        chk("rst_w_fill", 136'(fill_w), 136'(0));
        chk("rst_w_af", 136'(af_w), 136'(0));
        chk("rst_w_ae", 136'(ae_w), 136'(1));
        chk("rst_w_ready", 136'(bus_w.in_ready), 136'(1));
        chk("rst_p_valid", 136'(bus_p.out_valid), 136'(0));
        chk("rst_p_fill", 136'(fill_p), 136'(0));

        // Fill/drain, flags, flush
        for (int i = 0; i < 25; i++) begin
            bus_w.in_valid  = tbl[i].iv;
            bus_w.in_data   = DW'(tbl[i].d);
            bus_w.in_eop    = tbl[i].eop;
            bus_w.out_ready = tbl[i].ordy;
            flush           = tbl[i].fl;
            step();
            chk($sformatf("tbl%0d_valid", i), 136'(bus_w.out_valid), 136'(tbl[i].ov));
            if (tbl[i].ov)
                chk($sformatf("tbl%0d_data", i), 136'(bus_w.out_data), 136'(tbl[i].od));
            chk($sformatf("tbl%0d_fill", i), 136'(fill_w), 136'(tbl[i].fill));
            chk($sformatf("tbl%0d_af", i), 136'(af_w), 136'(tbl[i].af));
            chk($sformatf("tbl%0d_ae", i), 136'(ae_w), 136'(tbl[i].ae));
            chk($sformatf("tbl%0d_ready", i), 136'(bus_w.in_ready), 136'(tbl[i].ir));
        end
        flush = L;
        bus_w.in_valid = L;
        bus_w.out_ready = L;

        // Continuous push+pop at two occupancies
        run_stream(1);
        run_stream(3);

        // Packet mode: 3-word packet held until EOP stored
        bus_p.out_ready = H;
        push_p(8'h50, L); chk_p("pkt3_w0", L, 8'h00, L);
        push_p(8'h51, L); chk_p("pkt3_w1", L, 8'h00, L);
        push_p(8'h52, H); chk_p("pkt3_w2", L, 8'h00, L);
        step();           chk_p("pkt3_o0", H, 8'h50, L);
        step();           chk_p("pkt3_o1", H, 8'h51, L);
        step();           chk_p("pkt3_o2", H, 8'h52, H);
        step();           chk_p("pkt3_end", L, 8'h00, L);
        chk("pkt3_fill", 136'(fill_p), 136'(0));

        // Packet mode: 10-word packet forces cut-through
        sent = 0; rcv = 0; maxfill = 0;
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            bus_p.in_valid = (sent < 10);
            bus_p.in_data  = DW'(32'h200 + sent);
            bus_p.in_eop   = (sent == 9);
            pushed = bus_p.in_valid && bus_p.in_ready;
            popped = bus_p.out_valid && bus_p.out_ready;
            pd     = bus_p.out_data;
            pe     = bus_p.out_eop;
            step();
            if (pushed) sent++;
            if (popped) begin
                chk("pkt10_data", 136'(pd), 136'(32'h200 + rcv));
                chk("pkt10_eop", 136'(pe), 136'(rcv == 9));
                rcv++;
            end
            if (int'(fill_p) > maxfill) maxfill = int'(fill_p);
        end
        bus_p.in_valid = L;
        bus_p.in_eop   = L;
        chk("pkt10_received", 136'(rcv), 136'(10));
        chk("pkt10_maxfill", 136'(maxfill), 136'(8));
        step();
        chk("pkt10_empty", 136'(fill_p), 136'(0));

        // Back in HOLD: incomplete packet stays gated
        push_p(8'h30, L); chk_p("hold_w0", L, 8'h00, L);
        for (int k = 0; k < 3; k++) begin
            step(); chk_p("hold_gap", L, 8'h00, L);
        end
        push_p(8'h31, H); chk_p("hold_w1", L, 8'h00, L);
        step();           chk_p("hold_o0", H, 8'h30, L);
        step();           chk_p("hold_o1", H, 8'h31, H);
        step();           chk_p("hold_end", L, 8'h00, L);
        bus_p.out_ready = L;

        // Asynchronous reset mid-stream
        bus_w.out_ready = L;
        for (int k = 0; k < 4; k++) begin
            bus_w.in_valid = H;
            bus_w.in_data  = DW'(32'h40 + k);
            step();
        end
        bus_w.in_valid = L;
        chk("areset_pre_fill", 136'(fill_w), 136'(4));
        #3;
        reset_n = L;
        #1;
        chk("areset_valid", 136'(bus_w.out_valid), 136'(0));
        chk("areset_data", 136'(bus_w.out_data), 136'(0));
        chk("areset_fill", 136'(fill_w), 136'(0));
        chk("areset_ae", 136'(ae_w), 136'(1));
        chk("areset_af", 136'(af_w), 136'(0));
        chk("areset_ready", 136'(bus_w.in_ready), 136'(1));
        @(negedge clk);
        @(negedge clk);
        reset_n = H;
        bus_w.in_valid = H;
        bus_w.in_data  = DW'(32'h77);
        step();
        bus_w.in_valid = L;
        chk("post_rst_fill", 136'(fill_w), 136'(1));
        chk("post_rst_valid0", 136'(bus_w.out_valid), 136'(0));
        step();
        chk("post_rst_valid1", 136'(bus_w.out_valid), 136'(1));
        chk("post_rst_data", 136'(bus_w.out_data), 136'(32'h77));
        bus_w.out_ready = H;
        step();
        chk("post_rst_drain", 136'(bus_w.out_valid), 136'(0));
        chk("post_rst_fill0", 136'(fill_w), 136'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
